// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM generator and its counter-tracking helper.
package pwm_pkg;

    localparam int PWM_WIDTH = 8;

    localparam logic [PWM_WIDTH-1:0] CNT_MAX = {PWM_WIDTH{1'b1}};

    // Legacy-compatible state encoding; OFF must stay zero so a cleared register means idle.
    typedef logic [1:0] state_t;
    localparam state_t OFF  = 2'd0;
    localparam state_t SYNC = 2'd1;
    localparam state_t RUN  = 2'd2;

    function automatic logic is_live(input state_t s);
        return (s == SYNC) || (s == RUN);
    endfunction

endpackage

// File: rtl/cnt_edge_track.sv
// Remembers the previous sample of an up-counter and flags wrap (all-ones -> 0)
// and any other non-incrementing step as a discontinuity.
module cnt_edge_track #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             wrap,
    output logic             disc
);

    logic [WIDTH-1:0] cnt_q;
    logic             seen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_in;
            seen_q <= 1'b1;
        end
    end

    // Nothing is flagged until a first sample exists to compare against.
    always_comb begin
        wrap = seen_q && (cnt_q == {WIDTH{1'b1}}) && (cnt_in == '0);
        disc = seen_q && (cnt_in != cnt_q + WIDTH'(1)) && !wrap;
    end

endmodule

// File: rtl/pwm_gen.sv
// Registered PWM generator driven by an external free-running counter, with a
// one-entry duty shadow that is committed only on a period wrap.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             enable,
    input  logic             duty_valid,
    input  logic [WIDTH-1:0] duty_data,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic             sync_err,
    input  logic             err_clr
);

    logic             wrap;
    logic             disc;
    state_t           state_q;
    logic [WIDTH-1:0] active_q;
    logic [WIDTH-1:0] shadow_q;
    logic             pend_q;
    logic             transfer;
    logic             commit;
    logic [WIDTH-1:0] duty_eff;

    cnt_edge_track #(.WIDTH(WIDTH)) u_track (
        .clk    (clk),
        .rst_n  (rst_n),
        .cnt_in (cnt_in),
        .wrap   (wrap),
        .disc   (disc)
    );

    // A duty committing on this very wrap must already shape count 0 of the new period.
    always_comb begin
        transfer = duty_valid && !pend_q;
        commit   = wrap && is_live(state_q);
        duty_eff = (wrap && pend_q) ? shadow_q : active_q;
    end

    assign duty_ready = !pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            if (commit && pend_q) begin
                active_q <= shadow_q;
            end
            // A write landing on the wrap only fills the slot; it waits for the next wrap.
            if (transfer) begin
                shadow_q <= duty_data;
                pend_q   <= 1'b1;
            end else if (commit) begin
                pend_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            pwm_out <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    pwm_out <= 1'b0;
                    if (enable) begin
                        state_q <= SYNC;
                    end
                end
                SYNC: begin
                    pwm_out <= 1'b0;
                    if (!enable) begin
                        state_q <= OFF;
                    end else if (wrap) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        pwm_out <= 1'b0;
                        state_q <= OFF;
                    end else if (disc) begin
                        pwm_out <= 1'b0;
                        state_q <= SYNC;
                    end else begin
                        pwm_out <= (cnt_in < duty_eff);
                    end
                end
                default: begin
                    pwm_out <= 1'b0;
                    state_q <= OFF;
                end
            endcase
        end
    end

    // Losing sync is sticky; a clear arriving alongside a new loss is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            period_start <= wrap && enable && is_live(state_q);
            if ((state_q == RUN) && enable && disc) begin
                sync_err <= 1'b1;
            end else if (err_clr) begin
                sync_err <= 1'b0;
            end
        end
    end

endmodule
